// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word fetches over req/ready, presents one registered
// instruction per cycle with a one-entry skid for stalls and drain handling for redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic [31:0] next_pc,
  output logic [5:0]  opcode,
  output logic [4:0]  sub_op_base,
  output logic [7:0]  sub_op_ls,
  output logic        sub_op_j,
  output logic [4:0]  sub_op_jr
);

  typedef enum logic [1:0] {IDLE, FETCH, SKID, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drain_addr, drain_addr_nxt;
  logic [31:0] skid_word, skid_word_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic        valid_nxt;
  logic [31:0] instruction_nxt, instr_pc_nxt;
  logic        xfer;

  // Request and address depend on state only, so they cannot move until the handshake completes.
  assign im_req  = (state == FETCH) || (state == DRAIN);
  assign im_addr = (state == DRAIN) ? drain_addr : pc;
  assign xfer    = im_req && im_ready;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    drain_addr_nxt  = drain_addr;
    skid_word_nxt   = skid_word;
    skid_pc_nxt     = skid_pc;
    instruction_nxt = instruction;
    instr_pc_nxt    = instr_pc;
    valid_nxt       = instr_valid && stall;

    if (redirect) begin
      valid_nxt     = 1'b0;
      skid_word_nxt = 32'h0;
      skid_pc_nxt   = 32'h0;
      pc_nxt        = redirect_pc;
      case (state)
        FETCH: begin
          // An in-flight request cannot be withdrawn; park its address and drain it.
          if (!im_ready) begin
            drain_addr_nxt = pc;
            state_nxt      = DRAIN;
          end
        end
        DRAIN:   state_nxt = DRAIN;
        default: state_nxt = FETCH;
      endcase
    end else begin
      case (state)
        IDLE: state_nxt = FETCH;
        FETCH: begin
          if (xfer) begin
            pc_nxt = pc + 32'd4;
            if (!instr_valid || !stall) begin
              instruction_nxt = im_rdata;
              instr_pc_nxt    = pc;
              valid_nxt       = 1'b1;
            end else begin
              skid_word_nxt = im_rdata;
              skid_pc_nxt   = pc;
              state_nxt     = SKID;
            end
          end
        end
        SKID: begin
          if (!stall) begin
            instruction_nxt = skid_word;
            instr_pc_nxt    = skid_pc;
            valid_nxt       = 1'b1;
            state_nxt       = FETCH;
          end
        end
        DRAIN: begin
          if (im_ready) state_nxt = FETCH;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drain_addr  <= 32'h0;
      skid_word   <= 32'h0;
      skid_pc     <= 32'h0;
      instr_valid <= 1'b0;
      instruction <= 32'h0;
      instr_pc    <= 32'h0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      drain_addr  <= drain_addr_nxt;
      skid_word   <= skid_word_nxt;
      skid_pc     <= skid_pc_nxt;
      instr_valid <= valid_nxt;
      instruction <= instruction_nxt;
      instr_pc    <= instr_pc_nxt;
    end
  end

  assign next_pc     = instr_pc + 32'd4;
  assign opcode      = instruction[30:25];
  assign sub_op_base = instruction[4:0];
  assign sub_op_ls   = instruction[7:0];
  assign sub_op_j    = instruction[24];
  assign sub_op_jr   = instruction[4:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, wait states, skid, redirects, fields and PC wrap.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        im_ready;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        instr_valid;
  logic [31:0] instruction, instr_pc, next_pc;
  logic [5:0]  opcode;
  logic [4:0]  sub_op_base, sub_op_jr;
  logic [7:0]  sub_op_ls;
  logic        sub_op_j;

  logic        w_reset;
  logic        w_ready;
  logic [31:0] w_rdata;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instruction, w_instr_pc, w_next_pc;
  logic [5:0]  w_opcode;
  logic [4:0]  w_base, w_jr;
  logic [7:0]  w_ls;
  logic        w_j;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  assign im_rdata = im_addr;
  assign w_rdata  = 32'h4000_0080;

  fetch_unit dut (
    .clock(clock), .reset(reset), .im_req(im_req), .im_addr(im_addr),
    .im_ready(im_ready), .im_rdata(im_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instruction(instruction),
    .instr_pc(instr_pc), .next_pc(next_pc), .opcode(opcode), .sub_op_base(sub_op_base),
    .sub_op_ls(sub_op_ls), .sub_op_j(sub_op_j), .sub_op_jr(sub_op_jr)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clock(clock), .reset(w_reset), .im_req(w_req), .im_addr(w_addr),
    .im_ready(w_ready), .im_rdata(w_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(w_valid), .instruction(w_instruction),
    .instr_pc(w_instr_pc), .next_pc(w_next_pc), .opcode(w_opcode), .sub_op_base(w_base),
    .sub_op_ls(w_ls), .sub_op_j(w_j), .sub_op_jr(w_jr)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Leaves the main DUT in FETCH at address 0 with an empty slot.
  task automatic do_reset();
    reset = 1'b0; im_ready = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; im_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (im_req !== 1'b0) begin failures++; $display("FAIL reset_req cyc%0d: got %b want 0", i, im_req); end
    end
    checks++; if (im_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", im_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (instruction !== 32'h0 || instr_pc !== 32'h0) begin failures++; $display("FAIL reset_slot: got %h/%h want 0/0", instruction, instr_pc); end
    checks++; if (next_pc !== 32'h4) begin failures++; $display("FAIL reset_next_pc: got %h want 4", next_pc); end
    checks++; if ({opcode, sub_op_base, sub_op_ls, sub_op_j, sub_op_jr} !== 25'h0) begin failures++; $display("FAIL reset_fields: got %h want 0", {opcode, sub_op_base, sub_op_ls, sub_op_j, sub_op_jr}); end
    reset = 1'b1;
    step();
    checks++; if (im_req !== 1'b1 || im_addr !== 32'h0) begin failures++; $display("FAIL startup_req: got %b/%h want 1/0", im_req, im_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL startup_valid: got %b want 0", instr_valid); end
    // Reset while a request is pending drops it at the next edge.
    im_ready = 1'b0;
    reset = 1'b0;
    step();
    checks++; if (im_req !== 1'b0) begin failures++; $display("FAIL reset_mid_req: got %b want 0", im_req); end
  endtask

  task automatic test_stream();
    do_reset();
    im_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instruction !== 32'(4 * i) || instr_pc !== 32'(4 * i) || next_pc !== 32'(4 * i + 4)) begin
        failures++;
        $display("FAIL stream_%0d: got v=%b ins=%h pc=%h npc=%h want v=1 ins=%h pc=%h npc=%h",
                 i, instr_valid, instruction, instr_pc, next_pc, 32'(4 * i), 32'(4 * i), 32'(4 * i + 4));
      end
    end
    im_ready = 1'b0;
  endtask

  task automatic test_wait_states();
    logic [31:0] exp_word = 32'h0;
    logic [31:0] a;
    logic        rdy;
    do_reset();
    for (int cyc = 0; cyc < 12; cyc++) begin
      rdy = (cyc % 3 == 2);
      im_ready = rdy;
      a = im_addr;
      step();
      if (!rdy) begin
        checks++; if (im_req !== 1'b1 || im_addr !== a) begin failures++; $display("FAIL wait_stable_%0d: got %b/%h want 1/%h", cyc, im_req, im_addr, a); end
      end
      checks++; if (instr_valid !== rdy) begin failures++; $display("FAIL wait_valid_%0d: got %b want %b", cyc, instr_valid, rdy); end
      if (rdy) begin
        checks++; if (instruction !== exp_word) begin failures++; $display("FAIL wait_word_%0d: got %h want %h", cyc, instruction, exp_word); end
        exp_word = exp_word + 32'd4;
      end
    end
    im_ready = 1'b0;
  endtask

  task automatic test_stall_skid();
    do_reset();
    im_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (instruction !== 32'hC || im_addr !== 32'h10) begin failures++; $display("FAIL skid_pre: got %h/%h want c/10", instruction, im_addr); end
    stall = 1'b1;
    step();
    checks++; if (im_req !== 1'b0) begin failures++; $display("FAIL skid_req: got %b want 0", im_req); end
    checks++; if (instr_valid !== 1'b1 || instruction !== 32'hC) begin failures++; $display("FAIL skid_hold: got %b/%h want 1/c", instr_valid, instruction); end
    step();
    checks++; if (im_req !== 1'b0 || instruction !== 32'hC) begin failures++; $display("FAIL skid_hold2: got %b/%h want 0/c", im_req, instruction); end
    stall = 1'b0;
    step();
    checks++; if (instr_valid !== 1'b1 || instruction !== 32'h10 || instr_pc !== 32'h10) begin failures++; $display("FAIL skid_release: got %b/%h/%h want 1/10/10", instr_valid, instruction, instr_pc); end
    checks++; if (im_req !== 1'b1 || im_addr !== 32'h14) begin failures++; $display("FAIL skid_resume_req: got %b/%h want 1/14", im_req, im_addr); end
    step();
    checks++; if (instr_valid !== 1'b1 || instruction !== 32'h14) begin failures++; $display("FAIL skid_next: got %b/%h want 1/14", instr_valid, instruction); end
    step();
    checks++; if (instruction !== 32'h18) begin failures++; $display("FAIL skid_next2: got %h want 18", instruction); end
    im_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    im_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    im_ready = 1'b0;
    step();
    checks++; if (im_addr !== 32'h20 || instr_valid !== 1'b0) begin failures++; $display("FAIL redir_pre: got %h/%b want 20/0", im_addr, instr_valid); end
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    checks++; if (im_req !== 1'b1 || im_addr !== 32'h20) begin failures++; $display("FAIL redir_drain_addr: got %b/%h want 1/20", im_req, im_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_valid: got %b want 0", instr_valid); end
    step();
    checks++; if (im_addr !== 32'h20) begin failures++; $display("FAIL redir_drain_hold: got %h want 20", im_addr); end
    im_ready = 1'b1;
    step();
    checks++; if (im_req !== 1'b1 || im_addr !== 32'h100 || instr_valid !== 1'b0) begin failures++; $display("FAIL redir_target: got %b/%h/%b want 1/100/0", im_req, im_addr, instr_valid); end
    im_ready = 1'b0;
    step();
    checks++; if (instr_valid !== 1'b0 || im_addr !== 32'h100) begin failures++; $display("FAIL redir_wait: got %b/%h want 0/100", instr_valid, im_addr); end
    im_ready = 1'b1;
    step();
    checks++; if (instr_valid !== 1'b1 || instruction !== 32'h100 || instr_pc !== 32'h100) begin failures++; $display("FAIL redir_data: got %b/%h/%h want 1/100/100", instr_valid, instruction, instr_pc); end
    im_ready = 1'b0;
  endtask

  task automatic test_redirect_ready_stall();
    do_reset();
    im_ready = 1'b1;
    step();
    checks++; if (instr_valid !== 1'b1 || im_addr !== 32'h4) begin failures++; $display("FAIL rrs_pre: got %b/%h want 1/4", instr_valid, im_addr); end
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    stall = 1'b0; redirect = 1'b0;
    checks++; if (im_req !== 1'b1 || im_addr !== 32'h200) begin failures++; $display("FAIL rrs_next_req: got %b/%h want 1/200", im_req, im_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rrs_valid: got %b want 0", instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b1 || instruction !== 32'h200) begin failures++; $display("FAIL rrs_data: got %b/%h want 1/200", instr_valid, instruction); end
    im_ready = 1'b0;
  endtask

  task automatic test_fields_wrap();
    w_reset = 1'b0; w_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
    step(); step();
    w_reset = 1'b1;
    step();
    checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first_addr: got %b/%h want 1/fffffffc", w_req, w_addr); end
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    checks++; if (w_valid !== 1'b1 || w_instruction !== 32'h4000_0080 || w_instr_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_slot: got %b/%h/%h want 1/40000080/fffffffc", w_valid, w_instruction, w_instr_pc); end
    checks++; if (w_next_pc !== 32'h0) begin failures++; $display("FAIL wrap_next_pc: got %h want 0", w_next_pc); end
    checks++; if (w_opcode !== 6'h20) begin failures++; $display("FAIL field_opcode: got %h want 20", w_opcode); end
    checks++; if (w_base !== 5'h0 || w_jr !== 5'h0 || w_j !== 1'b0) begin failures++; $display("FAIL field_base_jr_j: got %h/%h/%b want 0/0/0", w_base, w_jr, w_j); end
    checks++; if (w_ls !== 8'h80) begin failures++; $display("FAIL field_ls: got %h want 80", w_ls); end
    checks++; if (w_addr !== 32'h0) begin failures++; $display("FAIL wrap_fetch_addr: got %h want 0", w_addr); end
  endtask

  initial begin
    w_reset = 1'b0; w_ready = 1'b0;
    reset = 1'b0; im_ready = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_wait_states();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_ready_stall();
    test_fields_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
